lookahead_routing_mc: RTL

Pipelined multicast lookahead routing unit for the 2D-mesh NoC router. It takes a header's destination list and the current-hop one-hot direction and produces:
- the next-hop direction set (OR over all destinations);
- a per-port destination mask, which the router's multicast fork uses to split the header.

Each destination is routed independently, dimension-ordered. XY or YX order is selected by a parameter. A one-stage valid/ready output register holds the result, and a sticky error flag plus a counter record out-of-mesh destinations.

---
 rtl/lookahead_routing_mc_pkg.sv | 40 ++++
 rtl/lookahead_routing_mc_dest_route.sv | 47 ++++
 rtl/lookahead_routing_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lookahead_routing_mc_pkg.sv
// Shared NoC types for the lookahead routing slice: coordinates, one-hot directions,
// port indices and the direction-to-port helper.
package lookahead_routing_mc_pkg;

    localparam int kCoordW   = 4;
    localparam int kNumPorts = 5;
    localparam int kPortW    = 3;

    typedef struct packed {
        logic [kCoordW-1:0] x;
        logic [kCoordW-1:0] y;
    } xy_t;

    typedef logic [kNumPorts-1:0] direction_t;

    localparam int kPortLocal = 0;
    localparam int kPortNorth = 1;
    localparam int kPortEast  = 2;
    localparam int kPortSouth = 3;
    localparam int kPortWest  = 4;

    localparam direction_t kGoLocal = 5'b00001;
    localparam direction_t kGoNorth = 5'b00010;
    localparam direction_t kGoEast  = 5'b00100;
    localparam direction_t kGoSouth = 5'b01000;
    localparam direction_t kGoWest  = 5'b10000;

    localparam logic [kCoordW-1:0] kCoordOne = 1;

    // Lowest set bit wins; callers only pass one-hot values.
    function automatic logic [kPortW-1:0] dir_to_port(input direction_t dir);
        logic [kPortW-1:0] port;
        port = '0;
        for (int p = kNumPorts - 1; p >= 0; p--) begin
            if (dir[p]) port = kPortW'(p);
        end
        return port;
    endfunction

endpackage

// File: rtl/lookahead_routing_mc_dest_route.sv
// Combinational dimension-ordered route for one multicast destination, evaluated
// against the next-hop position.
module lookahead_routing_mc_dest_route
    import lookahead_routing_mc_pkg::*;
#(
    parameter int YX_FIRST = 1,
    parameter int MESH_X   = 8,
    parameter int MESH_Y   = 8
) (
    input  xy_t        position,
    input  xy_t        hop,
    input  xy_t        dest,
    input  logic       dest_val,
    output direction_t dir,
    output logic       drop,
    output logic       oob
);

    logic x_oob;
    logic y_oob;

    assign x_oob = int'(dest.x) >= MESH_X;
    assign y_oob = int'(dest.y) >= MESH_Y;

    always_comb begin
        dir  = '0;
        drop = 1'b0;
        oob  = 1'b0;
        if (dest_val) begin
            if (x_oob || y_oob) begin
                oob  = 1'b1;
                drop = 1'b1;
            end else if (dest == position) begin
                drop = 1'b1;
            end else if (dest == hop) begin
                dir = kGoLocal;
            end else if (YX_FIRST != 0) begin
                if (dest.y != hop.y) dir = (dest.y < hop.y) ? kGoNorth : kGoSouth;
                else                 dir = (dest.x < hop.x) ? kGoWest  : kGoEast;
            end else begin
                if (dest.x != hop.x) dir = (dest.x < hop.x) ? kGoWest  : kGoEast;
                else                 dir = (dest.y < hop.y) ? kGoNorth : kGoSouth;
            end
        end
    end

endmodule

// File: rtl/lookahead_routing_mc.sv
// Pipelined multicast lookahead routing: per-destination next-hop routing, per-port
// fork masks, one-stage valid/ready output register and out-of-mesh error tracking.
module lookahead_routing_mc
    import lookahead_routing_mc_pkg::*;
#(
    parameter int DEST_SIZE = 4,
    parameter int YX_FIRST  = 1,
    parameter int MESH_X    = 8,
    parameter int MESH_Y    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  xy_t                                  position,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  xy_t                                  destination [0:DEST_SIZE-1],
    input  logic [DEST_SIZE-1:0]                 dest_val,
    input  direction_t                           current_routing,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output direction_t                           next_routing,
    output logic [kNumPorts-1:0][DEST_SIZE-1:0]  port_dest_mask,
    output logic [DEST_SIZE-1:0]                 drop_mask,
    output logic                                 err_oob,
    output logic [ERR_CNT_W-1:0]                 err_count,
    input  logic                                 err_clear
);

    localparam int CNT_W = $clog2(DEST_SIZE + 1);
    localparam int SUM_W = ERR_CNT_W + 1;

    xy_t pos_north;
    xy_t pos_south;
    xy_t pos_east;
    xy_t pos_west;
    xy_t hop;

    logic [1:0] warm_cnt;
    logic       warm_done;
    logic       accept;

    direction_t                          dir_d  [DEST_SIZE];
    logic       [DEST_SIZE-1:0]          drop_d;
    logic       [DEST_SIZE-1:0]          oob_d;
    direction_t                          next_routing_c;
    logic [kNumPorts-1:0][DEST_SIZE-1:0] port_dest_mask_c;
    logic [CNT_W-1:0]                    oob_cnt;
    logic [SUM_W-1:0]                    err_sum;
    logic [ERR_CNT_W-1:0]                err_count_c;

    // Neighbour coordinates are registered; edge underflow wraps and is later
    // rejected by the destination range check, never by the hop itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_north <= '0;
            pos_south <= '0;
            pos_east  <= '0;
            pos_west  <= '0;
            warm_cnt  <= '0;
        end else begin
            pos_north.x <= position.x;
            pos_north.y <= position.y - kCoordOne;
            pos_south.x <= position.x;
            pos_south.y <= position.y + kCoordOne;
            pos_east.x  <= position.x + kCoordOne;
            pos_east.y  <= position.y;
            pos_west.x  <= position.x - kCoordOne;
            pos_west.y  <= position.y;
            if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
        end
    end

    assign warm_done = (warm_cnt == 2'd2);
    assign in_ready  = warm_done & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    always_comb begin
        hop = position;
        if      (current_routing[kPortWest])  hop = pos_west;
        else if (current_routing[kPortEast])  hop = pos_east;
        else if (current_routing[kPortNorth]) hop = pos_north;
        else if (current_routing[kPortSouth]) hop = pos_south;
    end

    for (genvar d = 0; d < DEST_SIZE; d++) begin : g_dest
        lookahead_routing_mc_dest_route #(
            .YX_FIRST (YX_FIRST),
            .MESH_X   (MESH_X),
            .MESH_Y   (MESH_Y)
        ) u_route (
            .position (position),
            .hop      (hop),
            .dest     (destination[d]),
            .dest_val (dest_val[d]),
            .dir      (dir_d[d]),
            .drop     (drop_d[d]),
            .oob      (oob_d[d])
        );
    end

    always_comb begin
        next_routing_c   = '0;
        port_dest_mask_c = '0;
        oob_cnt          = '0;
        for (int d = 0; d < DEST_SIZE; d++) begin
            next_routing_c = next_routing_c | dir_d[d];
            if (dir_d[d] != '0) port_dest_mask_c[dir_to_port(dir_d[d])][d] = 1'b1;
            oob_cnt = oob_cnt + CNT_W'(oob_d[d]);
        end
    end

    always_comb begin
        err_sum     = SUM_W'(err_count) + SUM_W'(oob_cnt);
        err_count_c = err_sum[SUM_W-1] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            next_routing   <= '0;
            port_dest_mask <= '0;
            drop_mask      <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            next_routing   <= next_routing_c;
            port_dest_mask <= port_dest_mask_c;
            drop_mask      <= drop_d;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

    // A clear in the same cycle as an erroring accept wins outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob   <= 1'b0;
            err_count <= '0;
        end else if (err_clear) begin
            err_oob   <= 1'b0;
            err_count <= '0;
        end else if (accept && (oob_cnt != '0)) begin
            err_oob   <= 1'b1;
            err_count <= err_count_c;
        end
    end

endmodule
